// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the pc_gen_mr instruction-address generator.
// Holds the FSM state encoding, reset/increment defaults and the pending
// redirect record.
package pc_gen_pkg;

    // FSM states of the PC generator
    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HOLD = 2'd2
    } pc_state_e;

    // Default reset PC and sequential increment
    localparam logic [63:0] PC_START_ADDR = 64'h8000_0000;
    localparam int          PC_INST_BYTES = 4;

    // Record field widths: wide enough for any ADDR_W <= 64 and NUM_REDIR <= 256
    localparam int PC_REC_PC_W  = 64;
    localparam int PC_REC_IDX_W = 8;

    // Redirect record: one stored (pending) redirect request
    typedef struct packed {
        logic                    valid;
        logic [PC_REC_IDX_W-1:0] idx;
        logic [PC_REC_PC_W-1:0]  pc;
    } redir_rec_t;

endpackage

// File: rtl/pc_redir_prio.sv
// Combinational priority encoder over the redirect sources.
// Source 0 has the highest priority; outputs the winning index and target.
module pc_redir_prio
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int NUM_REDIR = 2,
    parameter int IDX_W     = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1
) (
    input  logic [NUM_REDIR-1:0]        i_valid,
    input  logic [NUM_REDIR*ADDR_W-1:0] i_pc,
    output logic                        o_valid,
    output logic [IDX_W-1:0]            o_idx,
    output logic [ADDR_W-1:0]           o_pc
);

    // Scan from lowest priority to highest so the lowest set index wins
    always_comb begin
        o_valid = |i_valid;
        o_idx   = '0;
        o_pc    = '0;
        for (int k = NUM_REDIR - 1; k >= 0; k--) begin
            if (i_valid[k]) begin
                o_idx = IDX_W'(k);
                o_pc  = i_pc[k*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/pc_gen_mr.sv
// Next instruction-address generator with prioritised redirect sources.
// Drives IF through pc_valid_o/pc_ready_i; a redirect raised while fetch is
// blocked is held in a single pending slot until the next accepted advance.
// Optional per-source applied-redirect counters: define PC_GEN_REDIR_CNT_EN.
//
// Handshake: pc_o is offered while pc_valid_o=1 and moves on only when
// pc_valid_o & pc_ready_i & ~stall_i; until then pc_o and pc_valid_o are
// held stable, and pc_valid_o never drops without an accept (except by rst).
module pc_gen_mr
    import pc_gen_pkg::*;
#(
    parameter int          ADDR_W     = 64,
    parameter int          NUM_REDIR  = 2,
    parameter logic [63:0] START_ADDR = PC_START_ADDR,
    parameter int          INST_BYTES = PC_INST_BYTES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REDIR-1:0]        redir_valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_pc_i,
    input  logic                        pred_valid_i,
    input  logic [ADDR_W-1:0]           pred_pc_i,
    input  logic                        stall_i,
    output logic [ADDR_W-1:0]           pc_o,
    output logic                        pc_valid_o,
    input  logic                        pc_ready_i,
    output logic                        redir_pend_o,
`ifdef PC_GEN_REDIR_CNT_EN
    output logic [NUM_REDIR*32-1:0]     redir_cnt_o,
`endif
    output logic [1:0]                  dbg_state_o
);

    localparam int IDX_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

    localparam logic [1:0] ST_BOOT = PC_BOOT;
    localparam logic [1:0] ST_RUN  = PC_RUN;
    localparam logic [1:0] ST_HOLD = PC_HOLD;

    logic [1:0]              r_state;
    logic [ADDR_W-1:0]       r_pc;
    logic                    r_pc_valid;
    redir_rec_t              r_pend;

    logic                    w_adv;
    logic                    w_cur_valid;
    logic [IDX_W-1:0]        w_cur_idx;
    logic [ADDR_W-1:0]       w_cur_pc;
    logic                    w_cur_wins;
    logic [ADDR_W-1:0]       w_pend_pc;
    logic [ADDR_W-1:0]       w_next_pc;

    pc_redir_prio #(
        .ADDR_W    (ADDR_W),
        .NUM_REDIR (NUM_REDIR),
        .IDX_W     (IDX_W)
    ) u_prio (
        .i_valid (redir_valid_i),
        .i_pc    (redir_pc_i),
        .o_valid (w_cur_valid),
        .o_idx   (w_cur_idx),
        .o_pc    (w_cur_pc)
    );

    assign w_adv     = r_pc_valid & pc_ready_i & ~stall_i;
    assign w_pend_pc = ADDR_W'(r_pend.pc);

    // A new redirect beats the pending one when it is the same or older stage
    assign w_cur_wins = w_cur_valid &
                        (~r_pend.valid | (PC_REC_IDX_W'(w_cur_idx) <= r_pend.idx));

    // Next fetch address on advance: redirect, pending, prediction, sequential
    always_comb begin
        w_next_pc = r_pc + ADDR_W'(INST_BYTES);
        if (w_cur_wins) begin
            w_next_pc = w_cur_pc;
        end else if (r_pend.valid) begin
            w_next_pc = w_pend_pc;
        end else if (pred_valid_i) begin
            w_next_pc = pred_pc_i;
        end
    end

    // PC, valid, pending slot and FSM state update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= ADDR_W'(START_ADDR);
            r_pc_valid <= 1'b0;
            r_pend     <= '0;
            r_state    <= ST_BOOT;
        end else begin
            r_pc_valid <= 1'b1;
            if (w_adv) begin
                r_pc    <= w_next_pc;
                r_pend  <= '0;
                r_state <= ST_RUN;
            end else if (w_cur_wins) begin
                r_pend.valid <= 1'b1;
                r_pend.idx   <= PC_REC_IDX_W'(w_cur_idx);
                r_pend.pc    <= PC_REC_PC_W'(w_cur_pc);
                r_state      <= ST_HOLD;
            end else if (r_state == ST_BOOT) begin
                r_state <= ST_RUN;
            end
        end
    end

    assign pc_o         = r_pc;
    assign pc_valid_o   = r_pc_valid;
    assign redir_pend_o = (r_state == ST_HOLD);
    assign dbg_state_o  = r_state;

`ifdef PC_GEN_REDIR_CNT_EN
    logic                          w_apply_valid;
    logic [PC_REC_IDX_W-1:0]       w_apply_idx;
    logic [NUM_REDIR-1:0][31:0]    r_cnt;

    assign w_apply_valid = w_adv & (w_cur_wins | r_pend.valid);
    assign w_apply_idx   = w_cur_wins ? PC_REC_IDX_W'(w_cur_idx) : r_pend.idx;

    // Count redirects that actually reach pc_o, saturating at all-ones
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REDIR; k++) begin
            if (rst) begin
                r_cnt[k] <= '0;
            end else if (w_apply_valid && (w_apply_idx == PC_REC_IDX_W'(k)) &&
                         (r_cnt[k] != 32'hFFFF_FFFF)) begin
                r_cnt[k] <= r_cnt[k] + 32'd1;
            end
        end
    end

    assign redir_cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_pc_gen_mr.sv
// Testbench for pc_gen_mr: reset/boot sequence, a table of single-cycle
// vectors covering priority, stall and pending behaviour, reset during HOLD,
// and a 32-bit instance for address wrap-around.
module tb_pc_gen_mr;
    import pc_gen_pkg::*;

    localparam int AW = 64;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     redir_valid_i = '0;
    logic [AW-1:0]     redir_pc0 = '0;
    logic [AW-1:0]     redir_pc1 = '0;
    logic              pred_valid_i = 1'b0;
    logic [AW-1:0]     pred_pc_i = '0;
    logic              stall_i = 1'b0;
    logic              pc_ready_i = 1'b0;
    logic [AW-1:0]     pc_o;
    logic              pc_valid_o;
    logic              redir_pend_o;
    logic [1:0]        dbg_state_o;

    logic [31:0]       w32_pc_o;
    logic              w32_pc_valid_o;
    logic              w32_redir_pend_o;
    logic [1:0]        w32_dbg_state_o;

`ifdef PC_GEN_REDIR_CNT_EN
    logic [NR*32-1:0]  redir_cnt_o;
    logic [NR*32-1:0]  w32_redir_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // clock / reset block
    always #5 clk = ~clk;

    pc_gen_mr #(.ADDR_W(AW), .NUM_REDIR(NR)) dut (
        .clk           (clk),
        .rst           (rst),
        .redir_valid_i (redir_valid_i),
        .redir_pc_i    ({redir_pc1, redir_pc0}),
        .pred_valid_i  (pred_valid_i),
        .pred_pc_i     (pred_pc_i),
        .stall_i       (stall_i),
        .pc_o          (pc_o),
        .pc_valid_o    (pc_valid_o),
        .pc_ready_i    (pc_ready_i),
        .redir_pend_o  (redir_pend_o),
`ifdef PC_GEN_REDIR_CNT_EN
        .redir_cnt_o   (redir_cnt_o),
`endif
        .dbg_state_o   (dbg_state_o)
    );

    pc_gen_mr #(.ADDR_W(32), .NUM_REDIR(NR), .START_ADDR(64'hFFFF_FFF8)) dut_w32 (
        .clk           (clk),
        .rst           (rst),
        .redir_valid_i (2'b00),
        .redir_pc_i    (64'h0),
        .pred_valid_i  (1'b0),
        .pred_pc_i     (32'h0),
        .stall_i       (1'b0),
        .pc_o          (w32_pc_o),
        .pc_valid_o    (w32_pc_valid_o),
        .pc_ready_i    (1'b1),
        .redir_pend_o  (w32_redir_pend_o),
`ifdef PC_GEN_REDIR_CNT_EN
        .redir_cnt_o   (w32_redir_cnt_o),
`endif
        .dbg_state_o   (w32_dbg_state_o)
    );

    typedef struct {
        logic [NR-1:0] rv;
        logic [AW-1:0] rpc0;
        logic [AW-1:0] rpc1;
        logic          pv;
        logic [AW-1:0] ppc;
        logic          stall;
        logic          ready;
        logic [AW-1:0] exp_pc;
        logic          exp_pend;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // one clock: inputs settle before the edge, outputs sampled 1ns after
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        redir_valid_i = '0;
        redir_pc0     = '0;
        redir_pc1     = '0;
        pred_valid_i  = 1'b0;
        pred_pc_i     = '0;
        stall_i       = 1'b0;
    endtask

    task automatic set_vec(input logic [NR-1:0] rv, input logic [63:0] p0, input logic [63:0] p1,
                           input logic pv, input logic [63:0] pp, input logic st, input logic rd,
                           input logic [63:0] epc, input logic epd, input int i);
        vecs[i].rv = rv;   vecs[i].rpc0 = p0;  vecs[i].rpc1 = p1;
        vecs[i].pv = pv;   vecs[i].ppc = pp;   vecs[i].stall = st;
        vecs[i].ready = rd; vecs[i].exp_pc = epc; vecs[i].exp_pend = epd;
    endtask

    initial begin
        // stimulus table: each row is one cycle, expected values after the edge
        set_vec(2'b00, 0, 0, 0, 0, 0, 1, 64'h8000_000C, 0, 0);
        set_vec(2'b00, 0, 0, 1, 64'h8000_1000, 0, 1, 64'h8000_1000, 0, 1);
        set_vec(2'b10, 0, 64'h8000_2000, 1, 64'h8000_1000, 0, 1, 64'h8000_2000, 0, 2);
        set_vec(2'b11, 64'h8000_2100, 64'h8000_2200, 0, 0, 0, 1, 64'h8000_2100, 0, 3);
        set_vec(2'b00, 0, 0, 0, 0, 0, 0, 64'h8000_2100, 0, 4);
        set_vec(2'b00, 0, 0, 1, 64'h8000_9000, 0, 0, 64'h8000_2100, 0, 5);
        set_vec(2'b00, 0, 0, 0, 0, 0, 1, 64'h8000_2104, 0, 6);
        set_vec(2'b10, 0, 64'h8000_3000, 0, 0, 1, 1, 64'h8000_2104, 1, 7);
        set_vec(2'b00, 0, 0, 0, 0, 1, 1, 64'h8000_2104, 1, 8);
        set_vec(2'b01, 64'h8000_4000, 0, 0, 0, 1, 1, 64'h8000_2104, 1, 9);
        set_vec(2'b00, 0, 0, 0, 0, 0, 1, 64'h8000_4000, 0, 10);
        set_vec(2'b00, 0, 0, 0, 0, 0, 1, 64'h8000_4004, 0, 11);
        set_vec(2'b01, 64'h8000_5000, 0, 0, 0, 1, 1, 64'h8000_4004, 1, 12);
        set_vec(2'b10, 0, 64'h8000_6000, 0, 0, 1, 1, 64'h8000_4004, 1, 13);
        set_vec(2'b00, 0, 0, 1, 64'h8000_7000, 0, 1, 64'h8000_5000, 0, 14);
        set_vec(2'b00, 0, 0, 0, 0, 0, 1, 64'h8000_5004, 0, 15);
        set_vec(2'b10, 0, 64'h8000_6000, 0, 0, 1, 1, 64'h8000_5004, 1, 16);
        set_vec(2'b10, 0, 64'h8000_6100, 0, 0, 0, 1, 64'h8000_6100, 0, 17);
        set_vec(2'b00, 0, 0, 0, 0, 0, 1, 64'h8000_6104, 0, 18);

        // reset and boot
        idle_inputs();
        pc_ready_i = 1'b1;
        rst = 1'b1;
        step();
        step();
        chk("rst_pc", pc_o, 64'h8000_0000);
        chk("rst_valid", pc_valid_o, 0);
        chk("rst_pend", redir_pend_o, 0);
        chk("rst_state", dbg_state_o, 2'(PC_BOOT));
        rst = 1'b0;
        #1;
        chk("boot_valid", pc_valid_o, 0);
        step();
        chk("run_pc0", pc_o, 64'h8000_0000);
        chk("run_valid", pc_valid_o, 1);
        chk("run_state", dbg_state_o, 2'(PC_RUN));
        chk("w32_pc0", w32_pc_o, 32'hFFFF_FFF8);
        step();
        chk("seq_pc1", pc_o, 64'h8000_0004);
        chk("w32_pc1", w32_pc_o, 32'hFFFF_FFFC);
        step();
        chk("seq_pc2", pc_o, 64'h8000_0008);
        chk("w32_wrap", w32_pc_o, 32'h0000_0000);

        // table-driven vectors
        for (int i = 0; i < 19; i++) begin
            redir_valid_i = vecs[i].rv;
            redir_pc0     = vecs[i].rpc0;
            redir_pc1     = vecs[i].rpc1;
            pred_valid_i  = vecs[i].pv;
            pred_pc_i     = vecs[i].ppc;
            stall_i       = vecs[i].stall;
            pc_ready_i    = vecs[i].ready;
            step();
            chk($sformatf("vec%0d_pc", i), pc_o, vecs[i].exp_pc);
            chk($sformatf("vec%0d_pend", i), redir_pend_o, vecs[i].exp_pend);
            chk($sformatf("vec%0d_valid", i), pc_valid_o, 1);
        end
        idle_inputs();

`ifdef PC_GEN_REDIR_CNT_EN
        chk("cnt0", redir_cnt_o[31:0], 3);
        chk("cnt1", redir_cnt_o[63:32], 2);
`endif

        // reset while a redirect is pending: it must be discarded
        pc_ready_i    = 1'b1;
        stall_i       = 1'b1;
        redir_valid_i = 2'b01;
        redir_pc0     = 64'h8000_A000;
        step();
        chk("hold_pend", redir_pend_o, 1);
        chk("hold_state", dbg_state_o, 2'(PC_HOLD));
        idle_inputs();
        stall_i = 1'b1;
        rst = 1'b1;
        step();
        chk("hrst_pc", pc_o, 64'h8000_0000);
        chk("hrst_pend", redir_pend_o, 0);
        chk("hrst_valid", pc_valid_o, 0);
`ifdef PC_GEN_REDIR_CNT_EN
        chk("hrst_cnt", redir_cnt_o, 0);
`endif
        rst = 1'b0;
        stall_i = 1'b0;
        step();
        chk("hboot_pc", pc_o, 64'h8000_0000);
        chk("hboot_valid", pc_valid_o, 1);
        step();
        chk("hnext_pc", pc_o, 64'h8000_0004);
        chk("hnext_pend", redir_pend_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
